alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 8, meaning max WAIT cycles before abort (>=4).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1: upstream command handshake.
REQ-006 SHALL have ports cmd_a input 2, cmd_b input 2, cmd_op input 2: operands and op code (00 add, 01 sub, 10 and, 11 or).
REQ-007 SHALL have ports alu_start output 1, alu_a output 2, alu_b output 2, alu_op output 2: drive to the multi-cycle ALU.
REQ-008 SHALL have ports alu_done input 1, alu_y input 3: ALU completion pulse and result.
REQ-009 SHALL have ports res_valid output 1, res_ready input 1, res_data output 3, res_err output 1: downstream result handshake.
REQ-010 SHALL have port fifo_count output clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-011 SHALL push a command when cmd_valid and cmd_ready are both 1 at a rising edge.
REQ-012 SHALL drive cmd_ready = 1 exactly when fifo_count < DEPTH; a same-cycle pop does not raise cmd_ready while full.
REQ-013 SHALL issue commands strictly in FIFO order, one outstanding at a time.
REQ-014 SHALL implement states IDLE, ISSUE, WAIT; reset state IDLE.
REQ-015 IDLE -> ISSUE when fifo_count > 0 and res_valid = 0; the FIFO head is popped and latched into alu_a/alu_b/alu_op on that edge.
REQ-016 SHALL assert alu_start = 1 only in ISSUE (exactly one cycle per command); ISSUE -> WAIT unconditionally.
REQ-017 SHALL hold alu_a/alu_b/alu_op stable from ISSUE until return to IDLE.
REQ-018 SHALL count WAIT cycles from 0 (first WAIT cycle) upward.
REQ-019 In WAIT with alu_done = 1: capture alu_y into res_data, res_err = 0, res_valid = 1, -> IDLE.
REQ-020 In WAIT with alu_done = 0 and count = TIMEOUT-1: res_data = 3'b000, res_err = 1, res_valid = 1, -> IDLE.
REQ-021 alu_done in the same cycle as count = TIMEOUT-1 SHALL be treated as success (REQ-019 wins).
REQ-022 SHALL ignore alu_done in IDLE and ISSUE.
REQ-023 SHALL hold res_valid/res_data/res_err stable until res_valid and res_ready both 1 at an edge, then clear res_valid.
REQ-024 With a compliant ALU (done 3 cycles after start) SHALL give res_valid 4 cycles after ISSUE; next ISSUE no earlier than 1 cycle after the result is consumed.
REQ-025 Simultaneous push and pop when not full SHALL leave fifo_count unchanged and both commands preserved.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH without loss or duplication.

Reset
REQ-027 On reset_n = 0, immediately: state IDLE, FIFO empty, fifo_count = 0, cmd_ready = 1 after release, alu_start = 0, alu_a/alu_b/alu_op = 0, res_valid = 0, res_data = 0, res_err = 0, WAIT counter = 0.
REQ-028 Reset mid-ISSUE or mid-WAIT SHALL discard the outstanding command and all queued commands; no result is produced for them.
REQ-029 After reset_n rises, first accepted command SHALL be issued normally.

Verification
REQ-030 Push add a=3 b=2 with ALU model -> alu_start one-cycle pulse, res_data = 3'b101, res_err = 0, res_valid 4 cycles after ISSUE.
REQ-031 Push sub a=1 b=2 -> res_data = 3'b111, res_err = 0; then and a=3 b=1 -> res_data = 3'b001, results in push order.
REQ-032 Hold res_ready = 0, push 5 commands -> 1 issued, 4 queued, cmd_ready = 0 with fifo_count = 4; release res_ready -> all 5 results in order.
REQ-033 Tie alu_done = 0 -> res_valid with res_err = 1, res_data = 3'b000 after 8 WAIT cycles; next command proceeds normally.
REQ-034 Pulse alu_done in IDLE, and assert reset_n = 0 during WAIT -> no spurious result; all outputs return to reset values; FIFO empty.
REQ-035 Continuous push/pop for 3*DEPTH commands -> pointer wrap with no loss, duplication, or reordering.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a FIFO and issues them one at a time to a multi-cycle ALU.
// Each result is held for the downstream consumer; an ALU that never answers yields an error result.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_a,
    input  logic [1:0]               cmd_b,
    input  logic [1:0]               cmd_op,
    output logic                     alu_start,
    output logic [1:0]               alu_a,
    output logic [1:0]               alu_b,
    output logic [1:0]               alu_op,
    input  logic                     alu_done,
    input  logic [2:0]               alu_y,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2:0]               res_data,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT);

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    cmd_t               mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    state_t             state, state_n;
    logic [TMO_W-1:0]   wcnt, wcnt_n;
    logic               push, pop;
    logic [CNT_W-1:0]   count_n;
    cmd_t               head;
    logic               alu_start_n;
    logic [1:0]         alu_a_n, alu_b_n, alu_op_n;
    logic               res_valid_n, res_err_n;
    logic [2:0]         res_data_n;

    assign push    = cmd_valid && cmd_ready;
    assign head    = mem[rd_ptr];
    assign count_n = fifo_count + CNT_W'(push) - CNT_W'(pop);

    // Command storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_n     = state;
        wcnt_n      = wcnt;
        pop         = 1'b0;
        alu_start_n = 1'b0;
        alu_a_n     = alu_a;
        alu_b_n     = alu_b;
        alu_op_n    = alu_op;
        res_valid_n = res_valid;
        res_data_n  = res_data;
        res_err_n   = res_err;

        if (res_valid && res_ready) begin
            res_valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                // A pending result blocks issue so results can never overwrite each other.
                if (fifo_count != '0 && !res_valid) begin
                    pop         = 1'b1;
                    state_n     = ISSUE;
                    alu_start_n = 1'b1;
                    alu_a_n     = head.a;
                    alu_b_n     = head.b;
                    alu_op_n    = head.op;
                end
            end
            ISSUE: begin
                state_n = WAIT;
                wcnt_n  = '0;
            end
            WAIT: begin
                // Completion takes priority over the final timeout cycle.
                if (alu_done) begin
                    res_valid_n = 1'b1;
                    res_data_n  = alu_y;
                    res_err_n   = 1'b0;
                    wcnt_n      = '0;
                    state_n     = IDLE;
                end else if (wcnt == TMO_W'(TIMEOUT - 1)) begin
                    res_valid_n = 1'b1;
                    res_data_n  = 3'b000;
                    res_err_n   = 1'b1;
                    wcnt_n      = '0;
                    state_n     = IDLE;
                end else begin
                    wcnt_n = wcnt + TMO_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wcnt       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmd_ready  <= 1'b1;
            alu_start  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b0;
        end else begin
            state      <= state_n;
            wcnt       <= wcnt_n;
            fifo_count <= count_n;
            cmd_ready  <= (count_n < CNT_W'(DEPTH));
            alu_start  <= alu_start_n;
            alu_a      <= alu_a_n;
            alu_b      <= alu_b_n;
            alu_op     <= alu_op_n;
            res_valid  <= res_valid_n;
            res_data   <= res_data_n;
            res_err    <= res_err_n;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural multi-cycle ALU.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_a, cmd_b, cmd_op;
    logic       alu_start;
    logic [1:0] alu_a, alu_b, alu_op;
    logic       alu_done;
    logic [2:0] alu_y;
    logic       res_valid, res_ready, res_err;
    logic [2:0] res_data;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    // ALU model controls
    bit         alu_en     = 1'b1;
    int         alu_lat    = 3;
    logic       done_force = 1'b0;
    logic       mdl_done, busy;
    logic [3:0] dly;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_start  (alu_start),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_done   (alu_done),
        .alu_y      (alu_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .fifo_count (fifo_count)
    );

    function automatic logic [2:0] alu_f(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // ALU answers alu_lat cycles after the start cycle
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            mdl_done <= 1'b0;
            dly      <= '0;
            alu_y    <= '0;
        end else begin
            mdl_done <= 1'b0;
            if (alu_start && alu_en) begin
                busy  <= 1'b1;
                dly   <= 4'd1;
                alu_y <= alu_f(alu_a, alu_b, alu_op);
            end else if (busy) begin
                if (dly == 4'(alu_lat - 1)) begin
                    mdl_done <= 1'b1;
                    busy     <= 1'b0;
                end else begin
                    dly <= dly + 4'd1;
                end
            end
        end
    end

    assign alu_done = mdl_done | done_force;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_wait: cmd_ready stuck at 0, required 1");
        end
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output bit seen);
        int n;
        n = 0;
        while (!alu_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        seen = alu_start;
        n_cmp++;
        if (alu_start !== 1'b1) begin
            n_bad++;
            $display("FAIL start_wait: alu_start=%b required 1", alu_start);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (fifo_count !== 3'd0 || res_valid !== 1'b0 || alu_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: count=%0d valid=%b start=%b required 0/0/0", fifo_count, res_valid, alu_start);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_op} !== 6'd0 || res_data !== 3'd0 || res_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_regs: alu=%h data=%0d err=%b required 0/0/0", {alu_a, alu_b, alu_op}, res_data, res_err);
        end
    endtask

    task automatic test_add_latency;
        bit seen;
        push(2'd3, 2'd2, 2'd0);
        wait_start(seen);
        n_cmp++;
        if (alu_a !== 2'd3 || alu_b !== 2'd2 || alu_op !== 2'd0) begin
            n_bad++;
            $display("FAIL add_issue: a=%0d b=%0d op=%0d required 3/2/0", alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        n_cmp++;
        if (alu_start !== 1'b0) begin
            n_bad++;
            $display("FAIL add_pulse: alu_start=%b required 0 one cycle after issue", alu_start);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL add_early: res_valid=%b required 0 three cycles after issue", res_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 3'b101 || res_err !== 1'b0) begin
            n_bad++;
            $display("FAIL add_result: valid=%b data=%b err=%b required 1/101/0", res_valid, res_data, res_err);
        end
        n_cmp++;
        if (alu_a !== 2'd3 || alu_b !== 2'd2 || alu_op !== 2'd0) begin
            n_bad++;
            $display("FAIL add_hold: a=%0d b=%0d op=%0d required 3/2/0", alu_a, alu_b, alu_op);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL add_consume: res_valid=%b required 0", res_valid);
        end
    endtask

    task automatic test_order;
        logic [2:0] exp_y [2] = '{3'b111, 3'b001};
        int n;
        push(2'd1, 2'd2, 2'd1);
        push(2'd3, 2'd1, 2'd2);
        res_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            while (!res_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== exp_y[i] || res_err !== 1'b0) begin
                n_bad++;
                $display("FAIL order[%0d]: valid=%b data=%b err=%b required 1/%b/0", i, res_valid, res_data, res_err, exp_y[i]);
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [1:0] ca [5] = '{2'd1, 2'd0, 2'd1, 2'd3, 2'd3};
        logic [1:0] cb [5] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [1:0] co [5] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2};
        logic [2:0] exp_y [5] = '{3'd2, 3'd7, 3'd3, 3'd6, 3'd2};
        int n;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(ca[i], cb[i], co[i]);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (fifo_count !== 3'd4 || cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_full: count=%0d ready=%b valid=%b required 4/0/1", fifo_count, cmd_ready, res_valid);
        end
        cmd_valid = 1'b1;
        cmd_a = 2'd2; cmd_b = 2'd2; cmd_op = 2'd3;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if (fifo_count !== 3'd4) begin
            n_bad++;
            $display("FAIL bp_reject: count=%0d required 4 after push attempt while full", fifo_count);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!res_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== exp_y[i] || res_err !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_result[%0d]: valid=%b data=%0d err=%b required 1/%0d/0", i, res_valid, res_data, res_err, exp_y[i]);
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
        n_cmp++;
        if (fifo_count !== 3'd0) begin
            n_bad++;
            $display("FAIL bp_drain: count=%0d required 0", fifo_count);
        end
    endtask

    // lat: ALU latency; timeout when the ALU never answers inside 8 WAIT cycles
    task automatic test_wait_limit(input bit en, input int lat, input logic [2:0] exp_d, input logic exp_e);
        bit seen;
        alu_en  = en;
        alu_lat = lat;
        push(2'd2, 2'd3, 2'd2);
        wait_start(seen);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL limit_early(en=%0d): res_valid=%b required 0 at last WAIT cycle", en, res_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== exp_d || res_err !== exp_e) begin
            n_bad++;
            $display("FAIL limit_result(en=%0d): valid=%b data=%b err=%b required 1/%b/%b", en, res_valid, res_data, res_err, exp_d, exp_e);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        alu_en  = 1'b1;
        alu_lat = 3;
    endtask

    task automatic test_recover_after_timeout;
        int n;
        push(2'd2, 2'd1, 2'd3);
        res_ready = 1'b1;
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 3'd3 || res_err !== 1'b0) begin
            n_bad++;
            $display("FAIL recover: valid=%b data=%0d err=%b required 1/3/0", res_valid, res_data, res_err);
        end
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_spurious_and_reset;
        bit seen;
        int n;
        done_force = 1'b1;
        @(negedge clk);
        done_force = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0 || alu_start !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_done: valid=%b start=%b required 0/0", res_valid, alu_start);
        end
        alu_en = 1'b0;
        push(2'd1, 2'd2, 2'd3);
        push(2'd2, 2'd2, 2'd0);
        push(2'd3, 2'd1, 2'd1);
        n_cmp++;
        if (fifo_count !== 3'd2 || alu_a !== 2'd1 || alu_op !== 2'd3) begin
            n_bad++;
            $display("FAIL pre_reset: count=%0d a=%0d op=%0d required 2/1/3", fifo_count, alu_a, alu_op);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (fifo_count !== 3'd0 || alu_start !== 1'b0 || {alu_a, alu_b, alu_op} !== 6'd0 ||
            res_valid !== 1'b0 || res_data !== 3'd0 || res_err !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: count=%0d start=%b alu=%h valid=%b data=%0d err=%b required all 0",
                     fifo_count, alu_start, {alu_a, alu_b, alu_op}, res_valid, res_data, res_err);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        res_ready = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (res_valid || alu_start) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset: activity=%b count=%0d ready=%b required 0/0/1", seen, fifo_count, cmd_ready);
        end
        alu_en = 1'b1;
        push(2'd1, 2'd2, 2'd3);
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 3'd3 || res_err !== 1'b0) begin
            n_bad++;
            $display("FAIL first_after_reset: valid=%b data=%0d err=%b required 1/3/0", res_valid, res_data, res_err);
        end
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back_wrap;
        logic [1:0] ca [12] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd0, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd2};
        logic [1:0] cb [12] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1, 2'd3, 2'd3, 2'd1};
        logic [1:0] co [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [2:0] exp_y [12] = '{3'd3, 3'd2, 3'd2, 3'd3, 3'd6, 3'd5, 3'd3, 3'd0, 3'd3, 3'd7, 3'd1, 3'd3};
        res_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 12; i++) push(ca[i], cb[i], co[i]);
            end
            begin
                int n;
                for (int j = 0; j < 12; j++) begin
                    n = 0;
                    while (!res_valid && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    n_cmp++;
                    if (res_valid !== 1'b1 || res_data !== exp_y[j] || res_err !== 1'b0) begin
                        n_bad++;
                        $display("FAIL wrap[%0d]: valid=%b data=%0d err=%b required 1/%0d/0", j, res_valid, res_data, res_err, exp_y[j]);
                    end
                    @(negedge clk);
                end
            end
        join
        repeat (10) @(negedge clk);
        n_cmp++;
        if (fifo_count !== 3'd0 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_end: count=%0d valid=%b required 0/0 (no duplicate)", fifo_count, res_valid);
        end
        res_ready = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_add_latency();
        test_order();
        test_backpressure();
        test_wait_limit(1'b0, 3, 3'b000, 1'b1);
        test_recover_after_timeout();
        test_wait_limit(1'b1, 8, 3'b010, 1'b0);
        test_spurious_and_reset();
        test_back_to_back_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
